op2_shift_seq: RTL and testbench



---
 rtl/op2_shift_seq_pkg.sv | 31 +++
 rtl/op2_shift_seq_if.sv | 35 +++
 rtl/op2_shift_seq_amount_plan.sv | 71 +++++++
 rtl/op2_shift_seq.sv | 143 ++++++++++++++
 tb/tb_op2_shift_seq.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/op2_shift_seq_pkg.sv
// op2_shift_seq shared types
// State encoding, Shifter codes and the plan bundle.
package op2_shift_seq_pkg;

  localparam int PASS_MAX_DEF = 16;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RS_REQ,
    S_RS_WAIT,
    S_PLAN,
    S_PASS1,
    S_PASS2,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0]  shType;
    logic [5:0]  amt;
    logic [1:0]  passes;
    logic [31:0] opnd;
    logic [31:0] bypRes;
    logic        bypC;
  } plan_t;

endpackage

// File: rtl/op2_shift_seq_if.sv
// op2_shift_seq bus
// Decode request, Rs read, Shifter link and result.
interface op2_shift_seq_if;
  logic        Start;
  logic        I;
  logic [11:0] Src2;
  logic [31:0] RmData;
  logic        CFlag;
  logic        RsReq;
  logic        RsValid;
  logic [7:0]  RsData;
  logic [1:0]  Sh;
  logic [4:0]  Shamt5;
  logic [31:0] ShIn;
  logic [31:0] ShOut;
  logic        ShifterCarry;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        CarryOut;

  modport slave (
    input  Start, I, Src2, RmData, CFlag,
    input  RsValid, RsData, ShOut, ShifterCarry,
    output RsReq, Sh, Shamt5, ShIn,
    output Busy, Done, Result, CarryOut
  );

  modport master (
    output Start, I, Src2, RmData, CFlag,
    output RsValid, RsData, ShOut, ShifterCarry,
    input  RsReq, Sh, Shamt5, ShIn,
    input  Busy, Done, Result, CarryOut
  );
endinterface

// File: rtl/op2_shift_seq_amount_plan.sv
// op2_amount_plan
// Resolves effective shift type/amount, pass count and bypass value.
module op2_amount_plan
  import op2_shift_seq_pkg::*;
#(
  parameter int PASS_MAX = PASS_MAX_DEF
) (
  input  logic        i,
  input  logic [11:0] src2,
  input  logic [7:0]  rsData,
  input  logic [31:0] rmData,
  input  logic        cFlag,
  output plan_t       plan
);

  logic [8:0] a;
  logic       byp;

  // Decode the three operand forms and their special amounts
  always_comb begin
    plan        = '0;
    plan.shType = src2[6:5];
    plan.opnd   = rmData;
    plan.bypRes = rmData;
    plan.bypC   = cFlag;
    a           = '0;
    byp         = 1'b0;
    if (i) begin
      plan.shType = SH_ROR;
      plan.opnd   = {24'b0, src2[7:0]};
      plan.bypRes = {24'b0, src2[7:0]};
      a           = {4'b0, src2[11:8], 1'b0};
      byp         = (src2[11:8] == 4'd0);
    end else if (!src2[4]) begin
      a = {4'b0, src2[11:7]};
      if (a == 9'd0) begin
        if (src2[6:5] == SH_LSL)
          byp = 1'b1;
        else if (src2[6:5] != SH_ROR)
          a = 9'd32;
      end
    end else begin
      a = {1'b0, rsData};
      if (a == 9'd0) begin
        byp = 1'b1;
      end else if (src2[6:5] == SH_ROR) begin
        a = {4'b0, rsData[4:0]};
        if (rsData[4:0] == 5'd0) begin
          byp       = 1'b1;
          plan.bypC = rmData[31];
        end
      end else if (a > 9'd32) begin
        if (src2[6:5] == SH_ASR) begin
          a = 9'd32;
        end else begin
          byp         = 1'b1;
          plan.bypRes = '0;
          plan.bypC   = 1'b0;
        end
      end
    end
    plan.amt = a[5:0];
    if (byp)
      plan.passes = 2'd0;
    else if (plan.shType != SH_ROR && a > 9'(PASS_MAX))
      plan.passes = 2'd2;
    else
      plan.passes = 2'd1;
  end

endmodule

// File: rtl/op2_shift_seq.sv
// op2_shift_seq
// Sequences Src2 evaluation through one or two external Shifter passes.
module op2_shift_seq
  import op2_shift_seq_pkg::*;
#(
  parameter int PASS_MAX = PASS_MAX_DEF
) (
  input logic          CLK,
  input logic          Reset,
  op2_shift_seq_if.slave bus
);

  state_t      state;
  logic        lI;
  logic [11:0] lSrc2;
  logic [31:0] lRm;
  logic        lC;
  logic [7:0]  lRs;
  logic        twoPass;
  logic [4:0]  p2Amt;
  logic        rsReq;
  logic        busy;
  logic        done;
  logic [1:0]  sh;
  logic [4:0]  shamt;
  logic [31:0] shIn;
  logic [31:0] result;
  logic        carry;
  plan_t       plan;
  logic [4:0]  p1Amt;

  op2_amount_plan #(.PASS_MAX(PASS_MAX)) uPlan (
    .i      (lI),
    .src2   (lSrc2),
    .rsData (lRs),
    .rmData (lRm),
    .cFlag  (lC),
    .plan   (plan)
  );

  assign p1Amt = (plan.passes == 2'd2) ? 5'(PASS_MAX) : plan.amt[4:0];

  // Control FSM with registered handshake and Shifter drive
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      lI      <= 1'b0;
      lSrc2   <= '0;
      lRm     <= '0;
      lC      <= 1'b0;
      lRs     <= '0;
      twoPass <= 1'b0;
      p2Amt   <= '0;
      rsReq   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sh      <= '0;
      shamt   <= '0;
      shIn    <= '0;
      result  <= '0;
      carry   <= 1'b0;
    end else begin
      rsReq <= 1'b0;
      done  <= 1'b0;
      sh    <= '0;
      shamt <= '0;
      shIn  <= '0;
      unique case (state)
        S_IDLE: begin
          if (bus.Start) begin
            lI    <= bus.I;
            lSrc2 <= bus.Src2;
            lRm   <= bus.RmData;
            lC    <= bus.CFlag;
            busy  <= 1'b1;
            if (!bus.I && bus.Src2[4]) begin
              state <= S_RS_REQ;
              rsReq <= 1'b1;
            end else begin
              state <= S_PLAN;
            end
          end
        end
        S_RS_REQ: state <= S_RS_WAIT;
        S_RS_WAIT: begin
          if (bus.RsValid) begin
            lRs   <= bus.RsData;
            state <= S_PLAN;
          end
        end
        S_PLAN: begin
          if (plan.passes == 2'd0) begin
            result <= plan.bypRes;
            carry  <= plan.bypC;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            sh      <= plan.shType;
            shamt   <= p1Amt;
            shIn    <= plan.opnd;
            twoPass <= (plan.passes == 2'd2);
            p2Amt   <= 5'(plan.amt - 6'(PASS_MAX));
            state   <= S_PASS1;
          end
        end
        S_PASS1: begin
          if (twoPass) begin
            sh    <= sh;
            shamt <= p2Amt;
            shIn  <= bus.ShOut;
            state <= S_PASS2;
          end else begin
            result <= bus.ShOut;
            carry  <= bus.ShifterCarry;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_PASS2: begin
          result <= bus.ShOut;
          carry  <= bus.ShifterCarry;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.RsReq    = rsReq;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Sh       = sh;
  assign bus.Shamt5   = shamt;
  assign bus.ShIn     = shIn;
  assign bus.Result   = result;
  assign bus.CarryOut = carry;

endmodule

// File: tb/tb_op2_shift_seq.sv
// tb_op2_shift_seq
// Directed and random Src2 checks against an ARM operand model.
module tb_op2_shift_seq;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int   vecs = 0;
  int   misc = 0;

  always #5 CLK = ~CLK;

  op2_shift_seq_if bus ();

  op2_shift_seq dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // Behavioural stand-in for the shared Shifter
  logic [32:0] t33;
  logic [31:0] r32;
  always_comb begin
    t33              = '0;
    r32              = '0;
    bus.ShOut        = bus.ShIn;
    bus.ShifterCarry = bus.CFlag;
    if (bus.Shamt5 != 5'd0) begin
      case (bus.Sh)
        2'b00: begin
          t33 = {1'b0, bus.ShIn} << bus.Shamt5;
          bus.ShOut = t33[31:0];
          bus.ShifterCarry = t33[32];
        end
        2'b01: begin
          t33 = {bus.ShIn, 1'b0} >> bus.Shamt5;
          bus.ShOut = t33[32:1];
          bus.ShifterCarry = t33[0];
        end
        2'b10: begin
          t33 = $signed({bus.ShIn, 1'b0}) >>> bus.Shamt5;
          bus.ShOut = t33[32:1];
          bus.ShifterCarry = t33[0];
        end
        default: begin
          r32 = (bus.ShIn >> bus.Shamt5) | (bus.ShIn << (32 - bus.Shamt5));
          bus.ShOut = r32;
          bus.ShifterCarry = r32[31];
        end
      endcase
    end else if (bus.Sh == 2'b11) begin
      bus.ShOut = {bus.CFlag, bus.ShIn[31:1]};
      bus.ShifterCarry = bus.ShIn[0];
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  // ARM shift by any amount 1..255
  function automatic void armShift(input logic [1:0] t, input logic [31:0] rm,
                                   input int n, output logic [31:0] r,
                                   output bit co);
    logic [63:0] x;
    case (t)
      2'b00: begin x = {32'b0, rm} << n; r = x[31:0]; co = x[32]; end
      2'b01: begin x = {rm, 32'b0} >> n; r = x[63:32]; co = x[31]; end
      2'b10: begin
        x = $signed({rm, 32'b0}) >>> n; r = x[63:32]; co = x[31];
      end
      default: begin
        if (n % 32 == 0) begin r = rm; co = rm[31]; end
        else begin r = rotr(rm, n % 32); co = r[31]; end
      end
    endcase
  endfunction

  // Reference: operand value, carry and Start-to-Done latency
  function automatic void refOp(input bit i, input logic [11:0] s,
                                input logic [31:0] rm, input bit c,
                                input logic [7:0] rs, output logic [31:0] r,
                                output bit co, output int lat);
    logic [1:0] t;
    int n;
    t = s[6:5];
    if (i) begin
      n = 2 * int'(s[11:8]);
      if (n == 0) begin
        r = {24'b0, s[7:0]}; co = c; lat = 2;
      end else begin
        r = rotr({24'b0, s[7:0]}, n); co = r[31]; lat = 3;
      end
    end else if (!s[4]) begin
      n = int'(s[11:7]);
      if (n == 0 && t == 2'b00) begin
        r = rm; co = c; lat = 2;
      end else if (n == 0 && t == 2'b11) begin
        r = {c, rm[31:1]}; co = rm[0]; lat = 3;
      end else begin
        if (n == 0) n = 32;
        armShift(t, rm, n, r, co);
        lat = (t != 2'b11 && n > 16) ? 4 : 3;
      end
    end else begin
      n = int'(rs);
      if (n == 0) begin
        r = rm; co = c; lat = 2;
      end else begin
        armShift(t, rm, n, r, co);
        if ((t == 2'b11 && n % 32 == 0) || (t[1] == 1'b0 && n > 32))
          lat = 2;
        else if (t != 2'b11 && n > 16)
          lat = 4;
        else
          lat = 3;
      end
      lat += 2;
    end
  endfunction

  task automatic runOp(input bit i, input logic [11:0] s, input logic [31:0] rm,
                       input bit c, input logic [7:0] rs, input int w,
                       input string nm, input bit useExp,
                       input logic [31:0] expR, input bit expC,
                       output logic [6:0] shSeen);
    logic [31:0] r;
    bit co, got, isReg;
    int lat, cyc, rq;
    refOp(i, s, rm, c, rs, r, co, lat);
    isReg = !i && s[4];
    if (isReg) lat += w;
    if (useExp) begin r = expR; co = expC; end
    bus.I = i; bus.Src2 = s; bus.RmData = rm; bus.CFlag = c;
    bus.RsValid = 1'b0; bus.RsData = 8'($urandom);
    bus.Start = 1'b1;
    cyc = 0; rq = 0; got = 1'b0; shSeen = '0;
    while (!got && cyc < 64) begin
      @(negedge CLK);
      cyc++;
      bus.Start = 1'b0;
      if (bus.RsReq) rq++;
      if (cyc == 2) shSeen = {bus.Sh, bus.Shamt5};
      if (isReg && cyc == 2 + w) begin bus.RsValid = 1'b1; bus.RsData = rs; end
      if (bus.Done) got = 1'b1;
    end
    vecs++;
    if (!got) begin
      misc++;
      $display("FAIL %s timeout: no Done in %0d cycles", nm, cyc);
    end else begin
      vecs++;
      if (cyc !== lat) begin
        misc++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, lat);
      end
      vecs++;
      if (bus.Result !== r) begin
        misc++; $display("FAIL %s result: got %h want %h", nm, bus.Result, r);
      end
      vecs++;
      if (bus.CarryOut !== co) begin
        misc++; $display("FAIL %s carry: got %b want %b", nm, bus.CarryOut, co);
      end
    end
    vecs++;
    if (rq !== int'(isReg)) begin
      misc++; $display("FAIL %s rsreq: got %0d want %0d", nm, rq, int'(isReg));
    end
    bus.RsValid = 1'b0;
    @(negedge CLK);
    vecs++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      misc++;
      $display("FAIL %s idle: got done=%b busy=%b want 0 0", nm, bus.Done, bus.Busy);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    vecs++;
    if ({bus.Busy, bus.Done, bus.RsReq, bus.CarryOut} !== 4'b0) begin
      misc++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.Busy, bus.Done, bus.RsReq, bus.CarryOut});
    end
    vecs++;
    if (bus.Result !== 32'h0) begin
      misc++; $display("FAIL reset_result: got %h want 0", bus.Result);
    end
    vecs++;
    if ({bus.Sh, bus.Shamt5, bus.ShIn} !== 39'h0) begin
      misc++;
      $display("FAIL reset_shifter: got %h want 0", {bus.Sh, bus.Shamt5, bus.ShIn});
    end
    Reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_spec_vectors;
    logic [6:0] sh;
    runOp(1, 12'h4FF, 32'h1234, 0, 0, 0, "imm_rot8", 1, 32'hFF000000, 1, sh);
    vecs++;
    if (sh !== {2'b11, 5'd8}) begin
      misc++; $display("FAIL imm_rot8_drive: got %h want %h", sh, {2'b11, 5'd8});
    end
    runOp(1, 12'h012, 32'hDEAD, 1, 0, 0, "imm_norot", 1, 32'h12, 1, sh);
    runOp(0, 12'h020, 32'h80000001, 0, 0, 0, "lsr32", 1, 32'h0, 1, sh);
    vecs++;
    if (sh !== {2'b01, 5'd16}) begin
      misc++; $display("FAIL lsr32_drive: got %h want %h", sh, {2'b01, 5'd16});
    end
    runOp(0, 12'h010, 32'hFFF, 0, 8'd20, 1, "reg_lsl20", 1, 32'hFFF00000, 0, sh);
    runOp(0, 12'h010, 32'hFFF, 1, 8'd40, 0, "reg_lsl40", 1, 32'h0, 0, sh);
    runOp(0, 12'h010, 32'h1, 0, 8'd32, 0, "reg_lsl32", 1, 32'h0, 1, sh);
    runOp(0, 12'h070, 32'h80000000, 0, 8'd64, 2, "reg_ror64", 1, 32'h80000000, 1, sh);
    runOp(0, 12'h050, 32'h80000000, 0, 8'd200, 0, "reg_asr200", 1, 32'hFFFFFFFF, 1, sh);
    runOp(0, 12'h060, 32'h3, 0, 0, 0, "rrx", 1, 32'h1, 1, sh);
    runOp(0, 12'h000, 32'hCAFE, 1, 0, 0, "lsl0", 1, 32'hCAFE, 1, sh);
  endtask

  task automatic test_reset_mid;
    int dn;
    logic [6:0] sh;
    runOp(1, 12'h4FF, 32'h0, 0, 0, 0, "pre_reset", 1, 32'hFF000000, 1, sh);
    bus.I = 1'b0; bus.Src2 = 12'h020; bus.RmData = 32'h80000001;
    bus.Start = 1'b1;
    repeat (3) begin @(negedge CLK); bus.Start = 1'b0; end
    vecs++;
    if (bus.Busy !== 1'b1) begin
      misc++; $display("FAIL mid_busy: got %b want 1", bus.Busy);
    end
    Reset = 1'b1;
    #1;
    vecs++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin
      misc++; $display("FAIL mid_reset_flags: got %b want 00", {bus.Busy, bus.Done});
    end
    vecs++;
    if (bus.Result !== 32'h0) begin
      misc++; $display("FAIL mid_reset_result: got %h want 0", bus.Result);
    end
    @(negedge CLK);
    Reset = 1'b0;
    dn = 0;
    repeat (8) begin @(negedge CLK); if (bus.Done) dn++; end
    vecs++;
    if (dn !== 0) begin
      misc++; $display("FAIL mid_reset_nodone: got %0d want 0", dn);
    end
  endtask

  task automatic test_busy_start;
    logic [31:0] r, rm;
    bit co, got;
    int lat, cyc, dn;
    rm = $urandom;
    refOp(0, 12'h280, rm, 0, 0, r, co, lat);
    bus.I = 1'b0; bus.Src2 = 12'h280; bus.RmData = rm; bus.CFlag = 1'b0;
    bus.Start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 64) begin
      @(negedge CLK);
      cyc++;
      bus.Start = (cyc == 1);
      if (cyc == 1) begin bus.I = 1'b1; bus.Src2 = 12'h4FF; bus.RmData = ~rm; end
      if (bus.Done) got = 1'b1;
    end
    bus.Start = 1'b0;
    vecs++;
    if (!got || cyc !== lat) begin
      misc++; $display("FAIL busy_start_latency: got %0d want %0d", cyc, lat);
    end
    vecs++;
    if (bus.Result !== r || bus.CarryOut !== co) begin
      misc++;
      $display("FAIL busy_start_result: got %h/%b want %h/%b",
               bus.Result, bus.CarryOut, r, co);
    end
    dn = 0;
    repeat (6) begin @(negedge CLK); if (bus.Done) dn++; end
    vecs++;
    if (dn !== 0 || bus.Busy !== 1'b0) begin
      misc++; $display("FAIL busy_start_extra: got done=%0d busy=%b want 0 0", dn, bus.Busy);
    end
  endtask

  task automatic test_random;
    logic [11:0] s;
    logic [7:0] rs;
    logic [6:0] sh;
    bit i;
    for (int k = 0; k < 150; k++) begin
      i = ($urandom % 3) == 0;
      s = 12'($urandom);
      if (!i && ($urandom % 2) == 1) begin s[4] = 1'b1; s[7] = 1'b0; end
      case ($urandom % 4)
        0: rs = 8'($urandom_range(0, 40));
        1: rs = 8'(($urandom % 8) * 32);
        default: rs = 8'($urandom);
      endcase
      runOp(i, s, $urandom, 1'($urandom), rs, $urandom % 3, "random",
            0, 32'h0, 0, sh);
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.I = 1'b0; bus.Src2 = '0; bus.RmData = '0;
    bus.CFlag = 1'b0; bus.RsValid = 1'b0; bus.RsData = '0;
    test_reset;
    test_spec_vectors;
    test_reset_mid;
    test_busy_start;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end

endmodule
